// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between the multicycle controller and the RV32I datapath
interface multicycle_controller_if #(
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int IMM_SRC_WIDTH  = 3
);
  // Instruction fields and ALU flags coming from the datapath
  logic [6:0]                op;
  logic [2:0]                funct3;
  logic                      funct7_5;
  logic                      Zero;
  logic                      N;
  logic                      C;
  logic                      V;
  logic                      mem_ready;

  // Strobes and selects going to the datapath
  logic                      PCWrite;
  logic                      IRWrite;
  logic                      RegWrite;
  logic                      MemWrite;
  logic                      AdrSrc;
  logic [1:0]                ALUSrcA;
  logic [1:0]                ALUSrcB;
  logic [1:0]                ResultSrc;
  logic [ALU_CTRL_WIDTH-1:0] ALUControl;
  logic [IMM_SRC_WIDTH-1:0]  ImmSrc;
  logic                      instr_done;
  logic                      illegal_op;

  modport master (
    input  op, funct3, funct7_5, Zero, N, C, V, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc,
           instr_done, illegal_op
  );

  modport slave (
    output op, funct3, funct7_5, Zero, N, C, V, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc,
           instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - one-state-per-cycle sequencing FSM for the multicycle RV32I core
module multicycle_controller #(
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int IMM_SRC_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master ctrl
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD  = ALU_CTRL_WIDTH'(0);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB  = ALU_CTRL_WIDTH'(1);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND  = ALU_CTRL_WIDTH'(2);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR   = ALU_CTRL_WIDTH'(3);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR  = ALU_CTRL_WIDTH'(4);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT  = ALU_CTRL_WIDTH'(5);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU = ALU_CTRL_WIDTH'(6);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL  = ALU_CTRL_WIDTH'(7);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL  = ALU_CTRL_WIDTH'(8);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA  = ALU_CTRL_WIDTH'(9);

  localparam logic [IMM_SRC_WIDTH-1:0] IMM_I = IMM_SRC_WIDTH'(0);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_S = IMM_SRC_WIDTH'(1);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_B = IMM_SRC_WIDTH'(2);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_J = IMM_SRC_WIDTH'(3);
  localparam logic [IMM_SRC_WIDTH-1:0] IMM_U = IMM_SRC_WIDTH'(4);

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_JALWB    = 4'd11,
    S_LUI      = 4'd12,
    S_BRANCH   = 4'd13
  } state_t;

  state_t state;
  state_t next_state;

  logic                      pc_write;
  logic                      ir_write;
  logic                      reg_write;
  logic                      mem_write;
  logic                      adr_src;
  logic [1:0]                alu_src_a;
  logic [1:0]                alu_src_b;
  logic [1:0]                result_src;
  logic [ALU_CTRL_WIDTH-1:0] alu_control;
  logic [IMM_SRC_WIDTH-1:0]  imm_src;
  logic                      done;
  logic                      illegal;

  // funct3/funct7 decode shared by register and immediate ALU instructions;
  // funct7_5 selects sub only for R-type, since addi carries an immediate bit there.
  function automatic logic [ALU_CTRL_WIDTH-1:0] alu_decode(
    input logic [2:0] f3,
    input logic       f7_5,
    input logic       is_rtype
  );
    case (f3)
      3'b000:  alu_decode = (is_rtype && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  // Flags come from rs1 - rs2 computed in the BRANCH cycle itself.
  function automatic logic branch_taken(
    input logic [2:0] f3,
    input logic       z,
    input logic       n,
    input logic       c,
    input logic       v
  );
    case (f3)
      3'b000:  branch_taken = z;
      3'b001:  branch_taken = ~z;
      3'b100:  branch_taken = n ^ v;
      3'b101:  branch_taken = ~(n ^ v);
      3'b110:  branch_taken = c;
      3'b111:  branch_taken = ~c;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  function automatic logic [IMM_SRC_WIDTH-1:0] imm_for_op(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:           imm_for_op = IMM_S;
      OP_BRANCH:          imm_for_op = IMM_B;
      OP_JAL:             imm_for_op = IMM_J;
      OP_LUI, OP_AUIPC:   imm_for_op = IMM_U;
      default:            imm_for_op = IMM_I;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = S_FETCH;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    done        = 1'b0;
    illegal     = 1'b0;

    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = ctrl.mem_ready;
        pc_write   = ctrl.mem_ready;
        next_state = ctrl.mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Speculative OldPC+imm lands in ALUOut for branch/JAL/AUIPC targets
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_for_op(ctrl.op);
        case (ctrl.op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_ALUWB;
          default: begin
            illegal    = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = (ctrl.op == OP_STORE) ? IMM_S : IMM_I;
        next_state = (ctrl.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        next_state = ctrl.mem_ready ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        done       = 1'b1;
      end

      S_MEMWRITE: begin
        // MemWrite stays up for the whole wait so the memory sees a stable request
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        done       = ctrl.mem_ready;
        next_state = ctrl.mem_ready ? S_FETCH : S_MEMWRITE;
      end

      S_EXECR: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = alu_decode(ctrl.funct3, ctrl.funct7_5, 1'b1);
        next_state  = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_I;
        alu_control = alu_decode(ctrl.funct3, ctrl.funct7_5, 1'b0);
        next_state  = S_ALUWB;
      end

      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        done       = 1'b1;
      end

      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link OldPC+4
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end

      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        next_state = S_JALWB;
      end

      S_JALWB: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        done       = 1'b1;
      end

      S_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
        done       = 1'b1;
      end

      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        imm_src     = IMM_B;
        pc_write    = branch_taken(ctrl.funct3, ctrl.Zero, ctrl.N, ctrl.C, ctrl.V);
        done        = 1'b1;
      end

      default: next_state = S_FETCH;
    endcase
  end

  // While reset is held the state already reads FETCH, so gate the strobes that FETCH would raise
  assign ctrl.PCWrite    = pc_write  & rst_n;
  assign ctrl.IRWrite    = ir_write  & rst_n;
  assign ctrl.RegWrite   = reg_write & rst_n;
  assign ctrl.MemWrite   = mem_write & rst_n;
  assign ctrl.instr_done = done      & rst_n;
  assign ctrl.illegal_op = illegal   & rst_n;
  assign ctrl.AdrSrc     = adr_src;
  assign ctrl.ALUSrcA    = alu_src_a;
  assign ctrl.ALUSrcB    = alu_src_b;
  assign ctrl.ResultSrc  = result_src;
  assign ctrl.ALUControl = alu_control;
  assign ctrl.ImmSrc     = imm_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven bench for multicycle_controller plus latency and reset-abort sequences
module tb_multicycle_controller;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // Observed bit layout: PCW IRW RW MW Adr A[2] B[2] RS[2] ALUC[4] Imm[3] done ill
  localparam logic [19:0] M_STRB = 20'hF0003;
  localparam logic [19:0] M_ADR  = 20'h08000;
  localparam logic [19:0] M_A    = 20'h06000;
  localparam logic [19:0] M_B    = 20'h01800;
  localparam logic [19:0] M_RS   = 20'h00600;
  localparam logic [19:0] M_ALUC = 20'h001E0;
  localparam logic [19:0] M_IMM  = 20'h0001C;

  localparam logic [19:0] M_F    = M_STRB | M_ADR | M_A | M_B | M_RS | M_ALUC;
  localparam logic [19:0] M_D    = M_STRB | M_A | M_B | M_ALUC | M_IMM;
  localparam logic [19:0] M_DNI  = M_STRB | M_A | M_B | M_ALUC;
  localparam logic [19:0] M_EX   = M_STRB | M_A | M_B | M_ALUC;
  localparam logic [19:0] M_EXI  = M_STRB | M_A | M_B | M_ALUC | M_IMM;
  localparam logic [19:0] M_WB   = M_STRB | M_RS;
  localparam logic [19:0] M_MEM  = M_STRB | M_ADR | M_RS;
  localparam logic [19:0] M_JMP  = M_STRB | M_A | M_B | M_ALUC | M_RS;
  localparam logic [19:0] M_JALR = M_STRB | M_A | M_B | M_ALUC | M_RS | M_IMM;
  localparam logic [19:0] M_LUI  = M_STRB | M_RS | M_IMM;
  localparam logic [19:0] M_BR   = M_STRB | M_A | M_B | M_ALUC | M_RS | M_IMM;

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic [3:0]  zncv;
    logic        mr;
    logic [19:0] exp;
    logic [19:0] mask;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs[$];
  logic [19:0] obs;

  multicycle_controller_if #(.ALU_CTRL_WIDTH(4), .IMM_SRC_WIDTH(3)) bus ();

  multicycle_controller #(.ALU_CTRL_WIDTH(4), .IMM_SRC_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus.master)
  );

  always #5 clk = ~clk;

  assign obs = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.ImmSrc,
                bus.instr_done, bus.illegal_op};

  function automatic logic [19:0] ev(
    input logic pcw, input logic irw, input logic rw, input logic mw, input logic adr,
    input logic [1:0] a, input logic [1:0] b, input logic [1:0] rs,
    input logic [3:0] aluc, input logic [2:0] imm, input logic dn, input logic ill
  );
    return {pcw, irw, rw, mw, adr, a, b, rs, aluc, imm, dn, ill};
  endfunction

  task automatic r(input string nm, input logic rs, input logic [6:0] op, input logic [2:0] f3,
                   input logic f75, input logic [3:0] zncv, input logic mr,
                   input logic [19:0] exp, input logic [19:0] mask);
    vec_t v;
    v.name = nm; v.rst = rs; v.op = op; v.f3 = f3; v.f75 = f75;
    v.zncv = zncv; v.mr = mr; v.exp = exp; v.mask = mask;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rs, input logic [6:0] op, input logic [2:0] f3,
                       input logic f75, input logic [3:0] zncv, input logic mr);
    rst_n = rs;
    bus.op = op; bus.funct3 = f3; bus.funct7_5 = f75;
    {bus.Zero, bus.N, bus.C, bus.V} = zncv;
    bus.mem_ready = mr;
  endtask

  task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  initial begin
    logic [19:0] e_f, e_fw, e_wb;
    int cyc;
    bit seen_done;

    e_f  = ev(1,1,0,0,0, 2'd0,2'd2,2'd2, 4'd0,3'd0, 0,0);
    e_fw = ev(0,0,0,0,0, 2'd0,2'd2,2'd2, 4'd0,3'd0, 0,0);
    e_wb = ev(0,0,1,0,0, 2'd0,2'd0,2'd0, 4'd0,3'd0, 1,0);

    drive(1'b0, OP_RTYPE, 3'b000, 1'b0, 4'b0000, 1'b1);

    r("reset_low",   0, OP_RTYPE, 0, 0, 4'b0000, 1, 20'h0, M_STRB);
    // add x3,x1,x2
    r("add_fetch",   1, OP_RTYPE, 0, 0, 4'b0000, 1, e_f, M_F);
    r("add_decode",  1, OP_RTYPE, 0, 0, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,0,0,0), M_DNI);
    r("add_execr",   1, OP_RTYPE, 0, 0, 4'b0000, 1, ev(0,0,0,0,0,2,0,0,0,0,0,0), M_EX);
    r("add_aluwb",   1, OP_RTYPE, 0, 0, 4'b0000, 1, e_wb, M_WB);
    // sub with a fetch wait first
    r("sub_fwait",   1, OP_RTYPE, 0, 1, 4'b0000, 0, e_fw, M_F);
    r("sub_fetch",   1, OP_RTYPE, 0, 1, 4'b0000, 1, e_f, M_F);
    r("sub_decode",  1, OP_RTYPE, 0, 1, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,0,0,0), M_DNI);
    r("sub_execr",   1, OP_RTYPE, 0, 1, 4'b0000, 1, ev(0,0,0,0,0,2,0,0,1,0,0,0), M_EX);
    r("sub_aluwb",   1, OP_RTYPE, 0, 1, 4'b0000, 1, e_wb, M_WB);
    // addi whose immediate has bit 30 set must still add
    r("addi_fetch",  1, OP_ITYPE, 0, 1, 4'b0000, 1, e_f, M_F);
    r("addi_decode", 1, OP_ITYPE, 0, 1, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,0,0,0), M_D);
    r("addi_execi",  1, OP_ITYPE, 0, 1, 4'b0000, 1, ev(0,0,0,0,0,2,1,0,0,0,0,0), M_EXI);
    r("addi_aluwb",  1, OP_ITYPE, 0, 1, 4'b0000, 1, e_wb, M_WB);
    // lw, two wait cycles in MEMREAD
    r("lw_fetch",    1, OP_LOAD, 3'b010, 0, 4'b0000, 1, e_f, M_F);
    r("lw_decode",   1, OP_LOAD, 3'b010, 0, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,0,0,0), M_D);
    r("lw_memadr",   1, OP_LOAD, 3'b010, 0, 4'b0000, 1, ev(0,0,0,0,0,2,1,0,0,0,0,0), M_EXI);
    r("lw_mrd_w1",   1, OP_LOAD, 3'b010, 0, 4'b0000, 0, ev(0,0,0,0,1,0,0,0,0,0,0,0), M_MEM);
    r("lw_mrd_w2",   1, OP_LOAD, 3'b010, 0, 4'b0000, 0, ev(0,0,0,0,1,0,0,0,0,0,0,0), M_MEM);
    r("lw_mrd_rdy",  1, OP_LOAD, 3'b010, 0, 4'b0000, 1, ev(0,0,0,0,1,0,0,0,0,0,0,0), M_MEM);
    r("lw_memwb",    1, OP_LOAD, 3'b010, 0, 4'b0000, 1, ev(0,0,1,0,0,0,0,1,0,0,1,0), M_WB);
    // sw, three wait cycles: MemWrite held four cycles
    r("sw_fetch",    1, OP_STORE, 3'b010, 0, 4'b0000, 1, e_f, M_F);
    r("sw_decode",   1, OP_STORE, 3'b010, 0, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,1,0,0), M_D);
    r("sw_memadr",   1, OP_STORE, 3'b010, 0, 4'b0000, 1, ev(0,0,0,0,0,2,1,0,0,1,0,0), M_EXI);
    r("sw_mw_w1",    1, OP_STORE, 3'b010, 0, 4'b0000, 0, ev(0,0,0,1,1,0,0,0,0,0,0,0), M_MEM);
    r("sw_mw_w2",    1, OP_STORE, 3'b010, 0, 4'b0000, 0, ev(0,0,0,1,1,0,0,0,0,0,0,0), M_MEM);
    r("sw_mw_w3",    1, OP_STORE, 3'b010, 0, 4'b0000, 0, ev(0,0,0,1,1,0,0,0,0,0,0,0), M_MEM);
    r("sw_mw_rdy",   1, OP_STORE, 3'b010, 0, 4'b0000, 1, ev(0,0,0,1,1,0,0,0,0,0,1,0), M_MEM);
    // branches: blt N=1 V=0 taken
    r("blt_fetch",   1, OP_BRANCH, 3'b100, 0, 4'b0100, 1, e_f, M_F);
    r("blt_decode",  1, OP_BRANCH, 3'b100, 0, 4'b0100, 1, ev(0,0,0,0,0,1,1,0,0,2,0,0), M_D);
    r("blt_nv10",    1, OP_BRANCH, 3'b100, 0, 4'b0100, 1, ev(1,0,0,0,0,2,0,0,1,2,1,0), M_BR);
    r("blt2_fetch",  1, OP_BRANCH, 3'b100, 0, 4'b0101, 1, e_f, M_F);
    r("blt2_decode", 1, OP_BRANCH, 3'b100, 0, 4'b0101, 1, ev(0,0,0,0,0,1,1,0,0,2,0,0), M_D);
    r("blt_nv11",    1, OP_BRANCH, 3'b100, 0, 4'b0101, 1, ev(0,0,0,0,0,2,0,0,1,2,1,0), M_BR);
    r("bgeu_fetch",  1, OP_BRANCH, 3'b111, 0, 4'b0000, 1, e_f, M_F);
    r("bgeu_decode", 1, OP_BRANCH, 3'b111, 0, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,2,0,0), M_D);
    r("bgeu_c0",     1, OP_BRANCH, 3'b111, 0, 4'b0000, 1, ev(1,0,0,0,0,2,0,0,1,2,1,0), M_BR);
    r("bgeu2_fetch", 1, OP_BRANCH, 3'b111, 0, 4'b0010, 1, e_f, M_F);
    r("bgeu2_dec",   1, OP_BRANCH, 3'b111, 0, 4'b0010, 1, ev(0,0,0,0,0,1,1,0,0,2,0,0), M_D);
    r("bgeu_c1",     1, OP_BRANCH, 3'b111, 0, 4'b0010, 1, ev(0,0,0,0,0,2,0,0,1,2,1,0), M_BR);
    r("beq_fetch",   1, OP_BRANCH, 3'b000, 0, 4'b1000, 1, e_f, M_F);
    r("beq_decode",  1, OP_BRANCH, 3'b000, 0, 4'b1000, 1, ev(0,0,0,0,0,1,1,0,0,2,0,0), M_D);
    r("beq_z1",      1, OP_BRANCH, 3'b000, 0, 4'b1000, 1, ev(1,0,0,0,0,2,0,0,1,2,1,0), M_BR);
    r("bne_fetch",   1, OP_BRANCH, 3'b001, 0, 4'b1000, 1, e_f, M_F);
    r("bne_decode",  1, OP_BRANCH, 3'b001, 0, 4'b1000, 1, ev(0,0,0,0,0,1,1,0,0,2,0,0), M_D);
    r("bne_z1",      1, OP_BRANCH, 3'b001, 0, 4'b1000, 1, ev(0,0,0,0,0,2,0,0,1,2,1,0), M_BR);
    r("b010_fetch",  1, OP_BRANCH, 3'b010, 0, 4'b1111, 1, e_f, M_F);
    r("b010_decode", 1, OP_BRANCH, 3'b010, 0, 4'b1111, 1, ev(0,0,0,0,0,1,1,0,0,2,0,0), M_D);
    r("b010_never",  1, OP_BRANCH, 3'b010, 0, 4'b1111, 1, ev(0,0,0,0,0,2,0,0,1,2,1,0), M_BR);
    // illegal opcode
    r("ill_fetch",   1, OP_BAD, 0, 0, 4'b0000, 1, e_f, M_F);
    r("ill_decode",  1, OP_BAD, 0, 0, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,0,0,1), M_DNI);
    r("ill_refetch", 1, OP_LUI, 0, 0, 4'b0000, 1, e_f, M_F);
    // lui / auipc
    r("lui_decode",  1, OP_LUI, 0, 0, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,4,0,0), M_D);
    r("lui_wb",      1, OP_LUI, 0, 0, 4'b0000, 1, ev(0,0,1,0,0,0,0,3,0,4,1,0), M_LUI);
    r("auipc_fetch", 1, OP_AUIPC, 0, 0, 4'b0000, 1, e_f, M_F);
    r("auipc_dec",   1, OP_AUIPC, 0, 0, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,4,0,0), M_D);
    r("auipc_wb",    1, OP_AUIPC, 0, 0, 4'b0000, 1, e_wb, M_WB);
    // jal / jalr
    r("jal_fetch",   1, OP_JAL, 0, 0, 4'b0000, 1, e_f, M_F);
    r("jal_decode",  1, OP_JAL, 0, 0, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,3,0,0), M_D);
    r("jal_jump",    1, OP_JAL, 0, 0, 4'b0000, 1, ev(1,0,0,0,0,1,2,0,0,0,0,0), M_JMP);
    r("jal_wb",      1, OP_JAL, 0, 0, 4'b0000, 1, e_wb, M_WB);
    r("jalr_fetch",  1, OP_JALR, 0, 0, 4'b0000, 1, e_f, M_F);
    r("jalr_decode", 1, OP_JALR, 0, 0, 4'b0000, 1, ev(0,0,0,0,0,1,1,0,0,0,0,0), M_D);
    r("jalr_jump",   1, OP_JALR, 0, 0, 4'b0000, 1, ev(1,0,0,0,0,2,1,2,0,0,0,0), M_JALR);
    r("jalr_wb",     1, OP_JALR, 0, 0, 4'b0000, 1, ev(0,0,1,0,0,1,2,2,0,0,1,0), M_JMP);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f75, vecs[i].zncv, vecs[i].mr);
      #1;
      check(vecs[i].name, obs & vecs[i].mask, vecs[i].exp & vecs[i].mask);
    end

    // Load latency with two MEMREAD waits, counted from the FETCH cycle
    cyc = 0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 20) begin
      cyc++;
      @(negedge clk);
      drive(1'b1, OP_LOAD, 3'b010, 1'b0, 4'b0000, (cyc == 4 || cyc == 5) ? 1'b0 : 1'b1);
      #1;
      seen_done = bus.instr_done;
    end
    check("lw_latency", 20'(cyc), 20'd7);

    // Reset during MEMWRITE aborts the store immediately
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, OP_STORE, 3'b010, 1'b0, 4'b0000, 1'b1);
    end
    @(negedge clk);
    drive(1'b1, OP_STORE, 3'b010, 1'b0, 4'b0000, 1'b0);
    #1;
    check("rst_mw_before", 20'(bus.MemWrite), 20'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mw_drop", {16'h0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}, 20'h0);
    @(negedge clk);
    drive(1'b1, OP_STORE, 3'b010, 1'b0, 4'b0000, 1'b0);
    #1;
    check("rst_fetch_wait", obs & M_F, e_fw & M_F);
    bus.mem_ready = 1'b1;
    #1;
    check("rst_fetch_irw", obs & M_F, e_f & M_F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
